mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported ideal memory (one write port, one read port used) between the instruction-fetch requester (I) and the load/store requester (D) of the multi-cycle CPU.
- Arbitrates per cycle and drives the memory port combinationally from the winner.
- Registers read data and returns it with a one-cycle rvalid pulse to the requester that issued the read.
- Supports a lock for multi-beat sequences (e.g. DMA-style copies through D).

Parameters:
ADDR_WIDTH, 10, word-address width; matches the memory's ADDR_WIDTH.
PRIORITY_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority, D wins.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_req  input  1  I request; held with i_we/i_addr/i_wdata/i_lock until i_gnt
i_we  input  1  I write (1) / read (0)
i_lock  input  1  I keeps ownership after this grant
i_addr  input  ADDR_WIDTH  I word address
i_wdata  input  32  I write data
i_gnt  output  1  I request accepted this cycle (combinational)
i_rvalid  output  1  I read data valid (registered pulse)
d_req, d_we, d_lock, d_addr, d_wdata, d_gnt, d_rvalid: same as the I set, for D
rdata  output  32  registered read data, shared by both requesters
mem_Waddr  output  ADDR_WIDTH  to memory Waddr
mem_Raddr  output  ADDR_WIDTH  to memory Raddr1
mem_Wren  output  1  to memory Wren
mem_Rden  output  1  to memory Rden1
mem_Wdata  output  32  to memory Wdata
mem_Rdata  input  32  from memory Rdata1

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, last_grant=D (first contest goes to I).
  - rdata=0, i_rvalid=d_rvalid=0.
  - i_gnt=d_gnt=0 and mem_Wren=mem_Rden=0, forced while rst_n is low.
- State machine: IDLE, OWN_I, OWN_D.
  - In IDLE:
    - Only one req asserted: grant it.
    - Both asserted, PRIORITY_MODE=0: grant the requester that is not last_grant.
    - Both asserted, PRIORITY_MODE=1: grant D.
  - In OWN_X: only X can be granted, and X is granted whenever X_req=1. The other requester waits with gnt=0.
- Transitions (at posedge):
  - IDLE to OWN_X: X granted with X_lock=1.
  - OWN_X to IDLE: X granted with X_lock=0, or X_req=0 in a cycle.
  - OWN_X to OWN_X: X granted with X_lock=1.
- last_grant updates to X on every grant to X.
- At most one grant per cycle. gnt is never asserted without the matching req.
- Memory drive in the grant cycle:
  - mem_Waddr = mem_Raddr = winner addr.
  - mem_Wdata = winner wdata.
  - mem_Wren = gnt & we.
  - mem_Rden = gnt & ~we.
  - No grant: Wren=Rden=0. Addresses and wdata are don't-care; drive 0.
- Write latency: the memory is written at the posedge ending the grant cycle. No rvalid is produced for a write.
- Read latency: rdata captures mem_Rdata at the posedge ending the grant cycle. The granted requester's rvalid is 1 for exactly the following cycle.
  - rdata holds its value until the next granted read.
  - Back-to-back reads are allowed. Grant N+1 can coincide with rvalid for grant N.
- Write then read of the same address in consecutive grants returns the new data (the memory reads asynchronously).
- The arbiter never reorders; there is only one outstanding read at a time.
- Reset mid-operation drops any pending rvalid and releases the lock.
- Requester rules:
  - A requester may deassert req only after gnt (not checked).
  - A requester may change addr/we/wdata only after gnt.

Test Plan:
- Reset then i_req=1, i_we=0, i_addr=5 (mem[5]=32'h2402_0000) -> i_gnt=1 same cycle, mem_Rden=1, mem_Raddr=5; next cycle i_rvalid=1, rdata=32'h2402_0000, d_rvalid=0.
- PRIORITY_MODE=0, i_req and d_req both held for 4 cycles, both reads -> grant order I, D, I, D. Each rvalid lands one cycle after its grant.
- PRIORITY_MODE=1, both requesting for 3 cycles -> D granted every cycle, i_gnt stays 0. After d_req drops, I is granted the next cycle.
- d_req with d_lock=1 and d_we=1, d_addr=100, d_wdata=7, then d_lock=1 read of 100, then d_lock=0 write of 101 while i_req is held throughout -> i_gnt=0 for all 3 D beats. The read returns 7. I is granted in cycle 4.
- D write of addr 50 = 32'hDEAD_BEEF, then I read of 50 in the next cycle -> rdata=32'hDEAD_BEEF, i_rvalid pulse, no d_rvalid.
- Read granted, then rst_n low before the next posedge -> rvalid stays 0, state=IDLE, the lock is cleared, and rdata=0 after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch I, load/store D) for a single-ported
// memory. Grants and the memory drive are combinational. Read data comes back
// registered, with a one-cycle rvalid pulse to the requester that issued it.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic                  i_lock,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic                  d_lock,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] mem_Waddr,
  output logic [ADDR_WIDTH-1:0] mem_Raddr,
  output logic                  mem_Wren,
  output logic                  mem_Rden,
  output logic [31:0]           mem_Wdata,
  input  logic [31:0]           mem_Rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_d;  // D won the most recent grant

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: take ownership on a locked grant, release on an unlocked grant or dropped req
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_gnt && i_lock)      state_nxt = OWN_I;
        else if (d_gnt && d_lock) state_nxt = OWN_D;
      end
      OWN_I:   if (!i_req || !i_lock) state_nxt = IDLE;
      OWN_D:   if (!d_req || !d_lock) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pick the winner and steer its request onto the memory port
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_Waddr = '0;
    mem_Raddr = '0;
    mem_Wdata = '0;
    mem_Wren  = 1'b0;
    mem_Rden  = 1'b0;
    if (rst_n) begin
      unique case (state)
        OWN_I: i_gnt = i_req;
        OWN_D: d_gnt = d_req;
        default: begin
          if (i_req && d_req) begin
            if (PRIORITY_MODE != 32'd0 || !last_d) d_gnt = 1'b1;
            else                                   i_gnt = 1'b1;
          end else begin
            i_gnt = i_req;
            d_gnt = d_req;
          end
        end
      endcase
    end
    if (i_gnt) begin
      mem_Waddr = i_addr;
      mem_Raddr = i_addr;
      mem_Wdata = i_wdata;
      mem_Wren  = i_we;
      mem_Rden  = ~i_we;
    end else if (d_gnt) begin
      mem_Waddr = d_addr;
      mem_Raddr = d_addr;
      mem_Wdata = d_wdata;
      mem_Wren  = d_we;
      mem_Rden  = ~d_we;
    end
  end

  // Fairness history, read data capture and rvalid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d   <= 1'b1;
      rdata    <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      i_rvalid <= i_gnt & ~i_we;
      d_rvalid <= d_gnt & ~d_we;
      if (i_gnt)      last_d <= 1'b0;
      else if (d_gnt) last_d <= 1'b1;
      if (mem_Rden) rdata <= mem_Rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: both priority modes run side by side, each with
// its own memory, request queues, reference model and rvalid scoreboard.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 10;

  typedef struct {
    bit          we;
    bit          lock;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  typedef struct {
    bit          who_d;
    logic [31:0] data;
    int          due;
  } rd_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int a);
    return (a == 5) ? 32'h2402_0000 : (32'hA500_0000 | 32'(a));
  endfunction

  function automatic txn_t mk(input bit we, input bit lock, input int addr,
                              input logic [31:0] wdata, input int gap);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = 10'(addr); t.wdata = wdata; t.gap = gap;
    return t;
  endfunction

  task automatic check(input int mode, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL m%0d %s: got %h, expected %h (cycle %0d)", mode, nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int PM = g;

    logic          rst_n = 1'b0;
    logic          i_req = 1'b0, i_we = 1'b0, i_lock = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_wdata = '0;
    logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_Wren, mem_Rden;
    logic [31:0]   rdata, mem_Wdata, mem_Rdata;
    logic [AW-1:0] mem_Waddr, mem_Raddr;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .PRIORITY_MODE(PM)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_we(i_we), .i_lock(i_lock), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .rdata(rdata),
      .mem_Waddr(mem_Waddr), .mem_Raddr(mem_Raddr), .mem_Wren(mem_Wren),
      .mem_Rden(mem_Rden), .mem_Wdata(mem_Wdata), .mem_Rdata(mem_Rdata)
    );

    // Ideal memory: asynchronous read, write at the clock edge
    logic [31:0] mem [1024];
    logic        mem_loaded = 1'b0;
    assign mem_Rdata = mem[mem_Raddr];
    always @(posedge clk) begin
      if (!mem_loaded) begin
        for (int k = 0; k < 1024; k++) mem[k] <= init_word(k);
        mem_loaded <= 1'b1;
      end else if (mem_Wren) begin
        mem[mem_Waddr] <= mem_Wdata;
      end
    end

    // Reference model state
    logic [31:0] shadow [1024];
    bit          sh_init = 1'b0;
    int          owner = 0;      // 0 nobody, 1 I, 2 D
    bit          last_was_d = 1'b1;
    bit          gi_q = 1'b0, gd_q = 1'b0;
    rd_t         rq[$];
    int          to_cnt = 0, to_seen = 0;
    bit          done = 1'b0;

    // Model: decide the expected winner from the arbitration rules and check the port
    always @(negedge clk) begin
      bit ei, ed;
      ei = 1'b0; ed = 1'b0;
      if (!sh_init) begin
        for (int k = 0; k < 1024; k++) shadow[k] = init_word(k);
        sh_init = 1'b1;
      end
      if (!rst_n) begin
        owner = 0;
        last_was_d = 1'b1;
      end else if (owner == 1) begin
        ei = i_req;
      end else if (owner == 2) begin
        ed = d_req;
      end else if (i_req && d_req) begin
        if (PM == 1 || !last_was_d) ed = 1'b1;
        else                        ei = 1'b1;
      end else begin
        ei = i_req;
        ed = d_req;
      end
      check(PM, "i_gnt", 32'(i_gnt), 32'(ei));
      check(PM, "d_gnt", 32'(d_gnt), 32'(ed));
      check(PM, "mem_Wren", 32'(mem_Wren), 32'((ei && i_we) || (ed && d_we)));
      check(PM, "mem_Rden", 32'(mem_Rden), 32'((ei && !i_we) || (ed && !d_we)));
      if (ei || ed) begin
        check(PM, "mem_Waddr", 32'(mem_Waddr), ei ? 32'(i_addr) : 32'(d_addr));
        check(PM, "mem_Raddr", 32'(mem_Raddr), ei ? 32'(i_addr) : 32'(d_addr));
        check(PM, "mem_Wdata", mem_Wdata, ei ? i_wdata : d_wdata);
      end
      if (ei) begin
        last_was_d = 1'b0;
        owner = i_lock ? 1 : 0;
        if (i_we) shadow[i_addr] = i_wdata;
        else      rq.push_back('{who_d: 1'b0, data: shadow[i_addr], due: cyc + 1});
      end else if (ed) begin
        last_was_d = 1'b1;
        owner = d_lock ? 2 : 0;
        if (d_we) shadow[d_addr] = d_wdata;
        else      rq.push_back('{who_d: 1'b1, data: shadow[d_addr], due: cyc + 1});
      end else if ((owner == 1 && !i_req) || (owner == 2 && !d_req)) begin
        owner = 0;
      end
      gi_q = ei;
      gd_q = ed;
    end

    // Monitor: rvalid pulses and rdata against the scoreboard of issued reads
    logic [31:0] exp_rdata = '0;
    always @(negedge clk) begin
      bit ev;
      ev = 1'b0;
      if (!rst_n) begin
        rq.delete();
        exp_rdata = '0;
        check(PM, "rst i_rvalid", 32'(i_rvalid), 32'd0);
        check(PM, "rst d_rvalid", 32'(d_rvalid), 32'd0);
      end else begin
        while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        check(PM, "i_rvalid", 32'(i_rvalid), 32'(ev && !rq[0].who_d));
        check(PM, "d_rvalid", 32'(d_rvalid), 32'(ev && rq[0].who_d));
        if (ev) begin
          exp_rdata = rq[0].data;
          void'(rq.pop_front());
        end
      end
      check(PM, "rdata", rdata, exp_rdata);
      if (to_cnt != to_seen) begin
        check(PM, "driver timeout", 32'(to_cnt), 32'(to_seen));
        to_seen = to_cnt;
      end
    end

    // Requesters: present queued transactions, holding each until granted
    txn_t qi[$], qd[$];
    txn_t cur[2];
    bit   cv[2] = '{1'b0, 1'b0};
    int   wc[2] = '{0, 0};

    task automatic cycle_step();
      @(posedge clk); #1;
      if (cv[0] && gi_q) cv[0] = 1'b0;
      if (cv[1] && gd_q) cv[1] = 1'b0;
      if (!cv[0] && qi.size() > 0) begin cur[0] = qi.pop_front(); cv[0] = 1'b1; wc[0] = cur[0].gap; end
      if (!cv[1] && qd.size() > 0) begin cur[1] = qd.pop_front(); cv[1] = 1'b1; wc[1] = cur[1].gap; end
      i_req = 1'b0;
      d_req = 1'b0;
      if (cv[0] && wc[0] > 0) wc[0]--;
      else if (cv[0]) begin
        i_req = 1'b1; i_we = cur[0].we; i_lock = cur[0].lock;
        i_addr = cur[0].addr; i_wdata = cur[0].wdata;
      end
      if (cv[1] && wc[1] > 0) wc[1]--;
      else if (cv[1]) begin
        d_req = 1'b1; d_we = cur[1].we; d_lock = cur[1].lock;
        d_addr = cur[1].addr; d_wdata = cur[1].wdata;
      end
    endtask

    task automatic run_until_empty(input int bound);
      int k;
      k = 0;
      do begin
        cycle_step();
        k++;
      end while ((qi.size() > 0 || qd.size() > 0 || cv[0] || cv[1]) && k < bound);
      if (k >= bound) to_cnt++;
    endtask

    initial begin
      int k;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single I read of a preloaded word
      qi.push_back(mk(1'b0, 1'b0, 5, 32'h0, 0));
      run_until_empty(50);

      // Both requesters reading continuously
      for (int n = 0; n < 3; n++) begin
        qi.push_back(mk(1'b0, 1'b0, 10 + n, 32'h0, 0));
        qd.push_back(mk(1'b0, 1'b0, 20 + n, 32'h0, 0));
      end
      run_until_empty(50);

      // Locked D sequence while I waits
      qd.push_back(mk(1'b1, 1'b1, 100, 32'd7, 0));
      qd.push_back(mk(1'b0, 1'b1, 100, 32'h0, 0));
      qd.push_back(mk(1'b1, 1'b0, 101, 32'h1234_5678, 0));
      qi.push_back(mk(1'b0, 1'b0, 101, 32'h0, 1));
      run_until_empty(50);

      // D write then I read of the same address
      qd.push_back(mk(1'b1, 1'b0, 50, 32'hDEAD_BEEF, 0));
      qi.push_back(mk(1'b0, 1'b0, 50, 32'h0, 1));
      run_until_empty(50);

      // Reset while a locked read is in flight
      qi.push_back(mk(1'b0, 1'b1, 7, 32'h0, 0));
      cycle_step();
      k = 0;
      do begin @(negedge clk); #1; k++; end while (!gi_q && k < 20);
      if (!gi_q) to_cnt++;
      rst_n = 1'b0;
      cv[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      i_req = 1'b0;
      qd.push_back(mk(1'b0, 1'b0, 9, 32'h0, 0));
      run_until_empty(50);

      // Randomized traffic on a small address window
      for (int n = 0; n < 300; n++) begin
        qi.push_back(mk(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                        $urandom_range(0, 15), $urandom,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
        qd.push_back(mk(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                        $urandom_range(0, 15), $urandom,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
      end
      run_until_empty(5000);
      repeat (4) cycle_step();
      done = 1'b1;
    end
  end

  initial begin
    int k;
    k = 0;
    while (!(g_inst[0].done && g_inst[1].done) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (!(g_inst[0].done && g_inst[1].done)) begin
      $display("FAIL global timeout: drivers did not finish, miscompares so far %0d", n_err);
      $fatal(1, "timeout");
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
